// File: rtl/south_link_receiver.sv
// North-side link receiver: FIFO-buffers incoming packets and routes each head
// to the south output (dy decremented) or the local sink; dy < 0 is dropped and counted.
module south_link_receiver #(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [15:0]              link_packet,
  input  logic                     link_valid,
  output logic                     link_ready,
  output logic [15:0]              packet_south,
  output logic                     valid_south,
  input  logic                     ready_south,
  output logic [15:0]              packet_local,
  output logic                     valid_local,
  input  logic                     ready_local,
  output logic [ERR_W-1:0]         err_count,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [15:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [15:0]      south_q, south_d;
  logic [15:0]      local_q, local_d;
  logic             vs_q, vs_d;
  logic             vl_q, vl_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic [15:0] head;
  logic        empty, full;
  logic        head_illegal, head_local, head_south;
  logic        south_free, local_free;
  logic        push, pop, load_south, load_local;

  assign head         = mem_q[rd_ptr_q];
  assign empty        = (count_q == '0);
  assign full         = (count_q == FULL_CNT);
  // dy is signed 4-bit: the sign bit alone marks an illegal packet
  assign head_illegal = head[11];
  assign head_local   = (head[11:8] == 4'd0);
  assign head_south   = !head[11] && (head[11:8] != 4'd0);
  assign south_free   = !vs_q || ready_south;
  assign local_free   = !vl_q || ready_local;

  assign load_south = !empty && head_south && south_free;
  assign load_local = !empty && head_local && local_free;
  assign pop        = load_south || load_local || (!empty && head_illegal);
  assign push       = link_valid && !full;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    south_d  = south_q;
    local_d  = local_q;
    vs_d     = vs_q;
    vl_d     = vl_q;
    err_d    = err_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;

    if (load_south) begin
      south_d = {head[15:12], head[11:8] - 4'd1, head[7:0]};
      vs_d    = 1'b1;
    end else if (vs_q && ready_south) begin
      vs_d = 1'b0;
    end

    if (load_local) begin
      local_d = head;
      vl_d    = 1'b1;
    end else if (vl_q && ready_local) begin
      vl_d = 1'b0;
    end

    if (!empty && head_illegal && (err_q != {ERR_W{1'b1}})) err_d = err_q + 1'b1;
  end

  // Storage is not reset; the pointers and count define what is valid
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= link_packet;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      south_q  <= 16'h0000;
      local_q  <= 16'h0000;
      vs_q     <= 1'b0;
      vl_q     <= 1'b0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      south_q  <= south_d;
      local_q  <= local_d;
      vs_q     <= vs_d;
      vl_q     <= vl_d;
      err_q    <= err_d;
    end
  end

  assign link_ready   = !full;
  assign packet_south = south_q;
  assign valid_south  = vs_q;
  assign packet_local = local_q;
  assign valid_local  = vl_q;
  assign err_count    = err_q;
  assign occupancy    = count_q;

endmodule

// File: tb/tb_south_link_receiver.sv
// Bench for south_link_receiver: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_south_link_receiver;

  localparam int DEPTH   = 4;
  localparam int ERR_W   = 8;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] link_packet;
  logic        link_valid;
  logic        link_ready;
  logic [15:0] packet_south;
  logic        valid_south;
  logic        ready_south;
  logic [15:0] packet_local;
  logic        valid_local;
  logic        ready_local;
  logic [ERR_W-1:0] err_count;
  logic [$clog2(DEPTH):0] occupancy;

  always #5 clk = ~clk;

  south_link_receiver #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .link_packet  (link_packet),
    .link_valid   (link_valid),
    .link_ready   (link_ready),
    .packet_south (packet_south),
    .valid_south  (valid_south),
    .ready_south  (ready_south),
    .packet_local (packet_local),
    .valid_local  (valid_local),
    .ready_local  (ready_local),
    .err_count    (err_count),
    .occupancy    (occupancy)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a queue of buffered packets plus one held slot per destination
  logic [15:0] mq[$];
  logic [15:0] m_ps, m_pl;
  logic        m_vs, m_vl;
  int          m_err;

  always @(posedge clk or negedge rst_n) begin : model
    logic [15:0] h;
    logic s_free, l_free, ld_s, ld_l, was_full;
    if (!rst_n) begin
      mq.delete();
      m_ps = 16'h0000; m_pl = 16'h0000;
      m_vs = 1'b0;     m_vl = 1'b0;
      m_err = 0;
    end else begin
      was_full = (mq.size() == DEPTH);
      s_free = !m_vs || ready_south;
      l_free = !m_vl || ready_local;
      ld_s = 1'b0; ld_l = 1'b0;
      if (mq.size() > 0) begin
        h = mq[0];
        if ($signed(h[11:8]) < 0) begin
          void'(mq.pop_front());
          if (m_err < ERR_MAX) m_err++;
        end else if (h[11:8] == 4'd0) begin
          if (l_free) begin void'(mq.pop_front()); m_pl = h; ld_l = 1'b1; end
        end else if (s_free) begin
          void'(mq.pop_front()); m_ps = h - 16'h0100; ld_s = 1'b1;
        end
      end
      if (ld_s) m_vs = 1'b1; else if (m_vs && ready_south) m_vs = 1'b0;
      if (ld_l) m_vl = 1'b1; else if (m_vl && ready_local) m_vl = 1'b0;
      if (link_valid && !was_full) mq.push_back(link_packet);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("valid_south",  32'(valid_south),  32'(m_vs));
    check("valid_local",  32'(valid_local),  32'(m_vl));
    check("packet_south", 32'(packet_south), 32'(m_ps));
    check("packet_local", 32'(packet_local), 32'(m_pl));
    check("err_count",    32'(err_count),    32'(m_err));
    check("occupancy",    32'(occupancy),    32'(mq.size()));
    check("link_ready",   32'(link_ready),   32'(mq.size() < DEPTH));
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
  endtask

  logic [15:0] rec[$];
  int idx;
  logic acc;

  initial begin
    rst_n = 1'b0; link_packet = 16'h0; link_valid = 1'b0;
    ready_south = 1'b0; ready_local = 1'b0;
    tick(); tick();
    check("rst_occ",   32'(occupancy), 0);
    check("rst_ready", 32'(link_ready), 1);
    check("rst_ps",    32'(packet_south), 0);
    rst_n = 1'b1;
    tick();

    // single south packet, two-cycle latency, one-cycle valid
    ready_south = 1'b1; ready_local = 1'b1;
    link_packet = 16'h3200; link_valid = 1'b1;
    tick(); link_valid = 1'b0;
    check("t1_early_vs", 32'(valid_south), 0);
    tick();
    check("t1_vs", 32'(valid_south), 1);
    check("t1_ps", 32'(packet_south), 32'h3100);
    check("t1_vl", 32'(valid_local), 0);
    tick();
    check("t1_vs_drop", 32'(valid_south), 0);

    // local then dy=7 south
    link_packet = 16'h5000; link_valid = 1'b1; tick();
    link_packet = 16'h07A5; tick();
    link_valid = 1'b0;
    check("t2_vl", 32'(valid_local), 1);
    check("t2_pl", 32'(packet_local), 32'h5000);
    tick();
    check("t2_vs", 32'(valid_south), 1);
    check("t2_ps", 32'(packet_south), 32'h06A5);
    tick(); tick();

    // illegal packets dropped and counted
    link_packet = 16'h0F00; link_valid = 1'b1; tick();
    link_packet = 16'h0800; tick();
    check("t3_err1", 32'(err_count), 1);
    check("t3_nov1", 32'(valid_south | valid_local), 0);
    link_packet = 16'h1000; tick();
    link_valid = 1'b0;
    check("t3_err2", 32'(err_count), 2);
    check("t3_nov2", 32'(valid_south | valid_local), 0);
    tick();
    check("t3_vl", 32'(valid_local), 1);
    check("t3_pl", 32'(packet_local), 32'h1000);
    check("t3_err", 32'(err_count), 2);
    tick(); tick();

    // backpressure fills FIFO
    ready_south = 1'b0; idx = 0;
    for (int c = 0; c < 8; c++) begin
      link_packet = 16'(16'h01A0 + idx); link_valid = (idx < 6);
      acc = link_valid && link_ready;
      tick();
      if (acc) idx++;
    end
    check("t4_accepted", 32'(idx), 5);
    check("t4_occ", 32'(occupancy), 4);
    check("t4_ready", 32'(link_ready), 0);
    check("t4_vs", 32'(valid_south), 1);
    check("t4_ps", 32'(packet_south), 32'h00A0);
    ready_south = 1'b1; rec.delete();
    for (int c = 0; c < 12; c++) begin
      if (valid_south) rec.push_back(packet_south);
      link_packet = 16'(16'h01A0 + idx); link_valid = (idx < 6);
      acc = link_valid && link_ready;
      tick();
      if (acc) idx++;
    end
    link_valid = 1'b0;
    check("t4_count", 32'(rec.size()), 6);
    for (int i = 0; i < 6; i++)
      check("t4_order", (i < rec.size()) ? 32'(rec[i]) : 32'hFFFF_FFFF, 32'(16'h00A0 + i));

    // head-of-line blocking
    ready_south = 1'b0; ready_local = 1'b1;
    link_valid = 1'b1;
    link_packet = 16'h01B0; tick();
    link_packet = 16'h02B1; tick();
    link_packet = 16'h00B2; tick();
    link_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("t5_blocked", 32'(valid_local), 0);
      tick();
    end
    check("t5_occ", 32'(occupancy), 2);
    ready_south = 1'b1; rec.delete();
    for (int c = 0; c < 6; c++) begin
      if (valid_south) rec.push_back(packet_south);
      if (valid_local) rec.push_back(packet_local);
      tick();
    end
    check("t5_count", 32'(rec.size()), 3);
    check("t5_a", (rec.size() > 0) ? 32'(rec[0]) : 32'hFFFF_FFFF, 32'h00B0);
    check("t5_b", (rec.size() > 1) ? 32'(rec[1]) : 32'hFFFF_FFFF, 32'h01B1);
    check("t5_c", (rec.size() > 2) ? 32'(rec[2]) : 32'hFFFF_FFFF, 32'h00B2);

    // asynchronous reset mid-stream
    ready_south = 1'b0; link_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      link_packet = 16'(16'h03C0 + i); tick();
    end
    link_valid = 1'b0;
    check("t6_pre_occ", 32'(occupancy), 3);
    check("t6_pre_vs", 32'(valid_south), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_vs",  32'(valid_south), 0);
    check("t6_ps",  32'(packet_south), 0);
    check("t6_occ", 32'(occupancy), 0);
    check("t6_rdy", 32'(link_ready), 1);
    check("t6_err", 32'(err_count), 0);
    tick();
    rst_n = 1'b1; ready_south = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t6_no_stale", 32'(valid_south | valid_local), 0);
    end

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      link_valid  = ($urandom_range(0, 9) < 7);
      link_packet = 16'($urandom);
      ready_south = ($urandom_range(0, 9) < 6);
      ready_local = ($urandom_range(0, 9) < 6);
      tick();
    end
    link_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/south_link_receiver.md
# south_link_receiver

Receiving end of the southward router link: accepts packets a neighbour's south forwarding stage drives onto the link, buffers them in a small FIFO, and dispatches each one either onward south (dy decremented) or to the local ejection port (dy == 0). Sits at the north input of each router tile, between the incoming link and the tile's south output and local sink. Illegal packets (dy < 0) are dropped and counted.

## Interface

- DEPTH, 4, FIFO depth in packets; power of 2, at least 2
- ERR_W, 8, width of the saturating error counter

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- link_packet  in  16  incoming packet; [11:8] = dy (signed 4-bit), all other bits opaque payload
- link_valid  in  1  link_packet is valid this cycle
- link_ready  out  1  FIFO can accept; equals !full
- packet_south  out  16  packet continuing south, dy already decremented
- valid_south  out  1  packet_south valid
- ready_south  in  1  south consumer accepts this cycle
- packet_local  out  16  packet ejected to this tile, unmodified
- valid_local  out  1  packet_local valid
- ready_local  in  1  local consumer accepts this cycle
- err_count  out  ERR_W  number of dropped dy < 0 packets, saturating
- occupancy  out  $clog2(DEPTH)+1  FIFO entries currently held

## Operation

- Push: on a clock edge where link_valid && link_ready, write link_packet into the FIFO tail.
- Head classification, with dy = head[11:8] signed:
  - dy > 0 (1..7): destined south; outgoing packet = head with [11:8] replaced by dy−1. Other bits are unchanged, and the value never wraps.
  - dy == 0: destined local; the packet is passed through unchanged.
  - dy < 0 (−8..−1): illegal. Pop the head with no output, and err_count += 1, saturating at 2^ERR_W−1.
- Output stages: one register per destination (south, local).
  - Destination x is free when !valid_x || ready_x.
  - Pop the FIFO head and load it into register x on an edge where the FIFO is non-empty, the head is destined for x, and x is free. valid_x is then 1.
  - Otherwise, valid_x is cleared on an edge where valid_x && ready_x.
  - While valid_x && !ready_x, packet_x and valid_x hold stable.
- Strict FIFO order. A blocked head blocks everything behind it, including packets for the other destination. At most one pop per cycle.
- An illegal head never blocks; it is popped on the first edge where it is the head.
- Full: link_ready = 0 and no push, even if a pop occurs in the same cycle (no write-through when full).
- Empty: no pop. The FIFO has no bypass; a packet always spends at least one cycle in the FIFO.
- Simultaneous push and pop while not full is allowed. occupancy is unchanged.
- Pointers wrap modulo DEPTH. occupancy counts 0..DEPTH.

## Timing

- Reset (rst_n low, asynchronous, any cycle including mid-transfer):
  - FIFO is emptied and contents discarded.
  - occupancy = 0, link_ready = 1.
  - valid_south = valid_local = 0, packet_south = packet_local = 16'h0000.
  - err_count = 0.
- Latency: a packet accepted at edge k becomes head after edge k; it is loaded into an output register at edge k+1 if its destination is free. valid_x is therefore high in the cycle after edge k+1 (2 cycles, unblocked).
- Throughput: one packet per cycle sustained when consumers hold ready high and destinations do not stall.
- link_ready depends only on registered state. Consumers may drop ready at any time, and data is held.

## Test plan

- Reset then single push of 16'h3200 (dy=2), ready_south=1 -> packet_south=16'h3100 with valid_south=1 exactly 2 cycles after acceptance, for one cycle; valid_local stays 0.
- Push 16'h5000 (dy=0) -> packet_local=16'h5000, valid_local=1 after 2 cycles; push 16'h07A5 (dy=7) -> packet_south=16'h06A5.
- Push 16'h0F00 (dy=−1) then 16'h0800 (dy=−8) then 16'h1000 -> err_count=2, no valid on either output for the first two packets, 16'h1000 delivered local.
- Hold ready_south=0 and push 6 south packets with DEPTH=4 -> 1 in output reg + 4 in FIFO, link_ready=0, occupancy=4, packet_south stable; release ready -> all 5 delivered in order, then the 6th is accepted.
- Order/head-of-line: ready_south=0 and push south pkt A, south pkt B, local pkt C -> C is not delivered until B leaves the FIFO; raise ready_south -> A, B, C in order.
- Assert rst_n=0 mid-stream with occupancy=3 and valid_south=1 -> all outputs return to reset values immediately (asynchronous), occupancy=0, no stale packet delivered after reset release.
